// File: rtl/decypher.sv
// One-time-pad decypher: walks a ciphertext word KEY_SIZE bits per cycle, MS chunk
// first, XORs each chunk with a pulled key chunk and presents the recovered word.
module decypher #(
    parameter int MSG_SIZE = 32,
    parameter int KEY_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_SIZE-1:0] cipher,
    output logic                key_req,
    input  logic                key_valid,
    input  logic [KEY_SIZE-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MSG_SIZE-1:0] plain,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for a cipher word, in_ready high
    // RUN   | pulling one key chunk per key_valid cycle, N chunks total
    // DONE  | plaintext presented, waiting for out_ready

    localparam int N     = MSG_SIZE / KEY_SIZE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt;
    logic [MSG_SIZE-1:0] ct;
    logic                take_key;

    assign take_key = (state_q == RUN) && key_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (key_valid && (cnt == LAST)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        key_req   = (state_q == RUN);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // The first recovered chunk shifts up into the plaintext MSBs, mirroring the
    // cypher's shift-left assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct    <= '0;
            plain <= '0;
            cnt   <= '0;
        end else if ((state_q == IDLE) && in_valid) begin
            ct    <= cipher;
            plain <= '0;
            cnt   <= '0;
        end else if (take_key) begin
            plain <= {plain[MSG_SIZE-KEY_SIZE-1:0], ct[MSG_SIZE-1 -: KEY_SIZE] ^ key};
            ct    <= ct << KEY_SIZE;
            cnt   <= (cnt == LAST) ? cnt : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decypher.sv
// Directed and loopback bench for decypher; expected plaintext goes into a
// scoreboard queue and a monitor compares it on each output handshake.
module tb_decypher;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] cipher;
    logic        key_req;
    logic        key_valid;
    logic [7:0]  key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] plain;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    decypher #(.MSG_SIZE(32), .KEY_SIZE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher    (cipher),
        .key_req   (key_req),
        .key_valid (key_valid),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain     (plain),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%0h expected=none", plain);
            end else begin
                check("plain", {32'd0, plain}, {32'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [31:0] ct, input logic [31:0] keys,
                            input logic [31:0] exp, input int stall_after,
                            input int stall_len, input int hold, input bit check_all);
        int g;
        int lat;
        int kidx;
        int kreq;
        int stall_rem;
        logic kv_now;
        logic kr_now;
        g = 0;
        while (!in_ready && g < 20) begin
            g++;
            tick();
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
            return;
        end
        sb.push_back(exp);
        in_valid = 1'b1;
        cipher   = ct;
        tick();
        in_valid = 1'b0;
        lat = 1;
        if (check_all) begin
            check("busy_run", {63'd0, busy}, 64'd1);
            check("in_ready_run", {63'd0, in_ready}, 64'd0);
        end
        kidx = 0;
        kreq = 0;
        stall_rem = stall_len;
        g = 0;
        while (!out_valid && g < 40) begin
            g++;
            kr_now = key_req;
            if (kr_now) kreq++;
            if (kidx == stall_after && stall_rem > 0) begin
                key_valid = 1'b0;
                stall_rem--;
            end else begin
                key_valid = 1'b1;
                key = (kidx < 4) ? keys[31-8*kidx -: 8] : 8'h00;
            end
            kv_now = key_valid;
            tick();
            lat++;
            if (kv_now && kr_now) kidx++;
        end
        key_valid = 1'b0;
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 expected=1");
            return;
        end
        check("latency", 64'(lat), 64'(5 + stall_len));
        check("key_req_cycles", 64'(kreq), 64'(4 + stall_len));
        if (check_all) check("key_req_done", {63'd0, key_req}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_plain", {32'd0, plain}, {32'd0, exp});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        if (check_all) check("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] msg;
        logic [31:0] keys;
        int g;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cipher    = '0;
        key_valid = 1'b0;
        key       = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_key_req", {63'd0, key_req}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_plain", {32'd0, plain}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_word(32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, -1, 0, 0, 1'b1);
        run_word(32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, -1, 0, 0, 1'b1);
        run_word(32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1, 2, 0, 1'b1);
        run_word(32'hCAFEF00D, 32'h11223344, 32'hDBDCC349, -1, 0, 6, 1'b1);

        // Reset after two chunks of a word: partial result must vanish.
        in_valid = 1'b1;
        cipher   = 32'h0BADF00D;
        tick();
        in_valid  = 1'b0;
        key_valid = 1'b1;
        key       = 8'h3C;
        tick();
        tick();
        key_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_key_req", {63'd0, key_req}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_plain", {32'd0, plain}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_word(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, -1, 0, 0, 1'b1);

        // Loopback through a cypher model: cipher chunk k = msg chunk k ^ key chunk k.
        for (int w = 0; w < 1000; w++) begin
            msg  = $urandom;
            keys = $urandom;
            run_word(msg ^ keys, keys, msg, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        g = 0;
        while (sb.size() != 0 && g < 20) begin
            g++;
            tick();
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
